// File: rtl/adder_share_pkg.sv
// Shared definitions for the adder-sharing arbiter.
//   ADDER_WIDTH_DEF / NUM_REQ_DEF : default operand width and requester count
//   rr_pick                       : round-robin search over a valid vector
package adder_share_pkg;

    localparam int ADDER_WIDTH_DEF = 91;
    localparam int NUM_REQ_DEF     = 4;
    localparam int MAX_REQ         = 16;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } rr_pick_t;

    // Returns the first set bit of valid, searching ptr, ptr+1, ... and
    // wrapping modulo num_req. Bits at or above num_req are ignored.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                         input logic [3:0]         ptr,
                                         input int                 num_req = NUM_REQ_DEF);
        rr_pick_t r;
        int       j;
        r.found = 1'b0;
        r.idx   = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            if (k < num_req) begin
                j = int'(ptr) + k;
                if (j >= num_req) j = j - num_req;
                if (!r.found && valid[j]) begin
                    r.found = 1'b1;
                    r.idx   = 4'(j);
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/adder_share_pipe.sv
// Two-stage shared adder datapath: operand registers, then sum register.
//   clk, reset          : clock, synchronous active-high reset
//   en                  : pipeline advance enable (low = hold everything)
//   in_valid/in_a/in_b/in_id : accepted transfer for this cycle
//   resp_valid/resp_id/resp_sum : registered result stage
module adder_share_pipe #(
    parameter int W    = 91,
    parameter int ID_W = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic            in_valid,
    input  logic [W-1:0]    in_a,
    input  logic [W-1:0]    in_b,
    input  logic [ID_W-1:0] in_id,
    output logic            resp_valid,
    output logic [ID_W-1:0] resp_id,
    output logic [W:0]      resp_sum
);

    logic            s1_valid;
    logic [W-1:0]    s1_a;
    logic [W-1:0]    s1_b;
    logic [ID_W-1:0] s1_id;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_id    <= '0;
        end else if (en) begin
            s1_valid <= in_valid;
            // data registers only move on a real transfer; bubbles keep old data
            if (in_valid) begin
                s1_a  <= in_a;
                s1_b  <= in_b;
                s1_id <= in_id;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_sum   <= '0;
        end else if (en) begin
            resp_valid <= s1_valid;
            if (s1_valid) begin
                resp_sum <= {1'b0, s1_a} + {1'b0, s1_b};
                resp_id  <= s1_id;
            end
        end
    end

endmodule

// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one registered adder among NUM_REQ requesters.
//   clk, reset                  : clock, synchronous active-high reset
//   req_valid/req_a/req_b       : per-requester operand pairs (packed slices)
//   req_ready                   : one-hot grant, zero while stalled or in reset
//   resp_valid/resp_id/resp_sum : result, tagged with issuing requester
//   resp_ready                  : consumer accept; low stalls the whole pipe
module adder_share_arbiter
    import adder_share_pkg::*;
#(
    parameter int  ADDER_WIDTH = ADDER_WIDTH_DEF,
    parameter int  NUM_REQ     = NUM_REQ_DEF,
    localparam int ID_W        = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*ADDER_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*ADDER_WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           resp_valid,
    output logic [ID_W-1:0]                resp_id,
    output logic [ADDER_WIDTH:0]           resp_sum,
    input  logic                           resp_ready
);

    logic [ID_W-1:0]        ptr;
    logic [ID_W-1:0]        gnt;
    rr_pick_t               pick;
    logic                   en;
    logic                   xfer;
    logic [ADDER_WIDTH-1:0] sel_a;
    logic [ADDER_WIDTH-1:0] sel_b;

    always_comb begin
        pick      = rr_pick(MAX_REQ'(req_valid), 4'(ptr), NUM_REQ);
        gnt       = ID_W'(pick.idx);
        en        = !resp_valid || resp_ready;
        // reset masks the grant so nothing is handshaken during reset
        xfer      = en && pick.found && !reset;
        req_ready = '0;
        if (xfer) req_ready[gnt] = 1'b1;
    end

    assign sel_a = req_a[int'(gnt)*ADDER_WIDTH +: ADDER_WIDTH];
    assign sel_b = req_b[int'(gnt)*ADDER_WIDTH +: ADDER_WIDTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (xfer) begin
            ptr <= (gnt == ID_W'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
        end
    end

    adder_share_pipe #(
        .W    (ADDER_WIDTH),
        .ID_W (ID_W)
    ) u_pipe (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .in_valid   (xfer),
        .in_a       (sel_a),
        .in_b       (sel_b),
        .in_id      (gnt),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_sum   (resp_sum)
    );

endmodule
